muldiv_sequencer: RTL

- Multi-cycle controller for RV32M multiply/divide operations in the Execute stage.
- Sits beside the single-cycle ALU. It accepts an M-extension op when the ALU-op decode flags funct7 = 7'b0000001.
- Iterates a shift-add multiplier or a restoring divider over 32 cycles, stalling the pipeline until the result is ready.
- Result is muxed onto the Execute result bus when done pulses.

---
 rtl/muldiv_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit for the Execute stage.
// A 32-step shift-add multiplier and a 32-step restoring divider share one
// 64-bit accumulator. Operands are kept as magnitudes plus sign bits, and the
// sign is applied once the op finishes.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (wins over flush and start)
//   start     op request, only looked at in IDLE
//   flush     pipeline kill: abort to IDLE and suppress done
//   funct3    M op select (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   rs1_data  operand A (multiplicand / dividend)
//   rs2_data  operand B (multiplier / divisor)
//   busy      state != IDLE
//   done      one-cycle result-valid pulse
//   result    op result, held until the next done
//
// Build option: define MULDIV_FAST_MUL_EN to give multiplies a single-cycle
// combinational product (IDLE->DONE). Divides are unchanged.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [2:0]        op;
  logic              sa, sb, special;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   opnd;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc;      // mul: {partial hi, multiplier}; div: {rem, quo}
  logic [XLEN-1:0]   result_q;

  // Operand decode on the request.
  logic            sgn_a, sgn_b, neg_a, neg_b, div_zero, ovf, spec_in, fast_mul, accept;
  logic [XLEN-1:0] abs_a, abs_b, spec_val;

  always_comb begin
    sgn_a    = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
    sgn_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
    neg_a    = sgn_a & rs1_data[XLEN-1];
    neg_b    = sgn_b & rs2_data[XLEN-1];
    abs_a    = neg_a ? -rs1_data : rs1_data;
    abs_b    = neg_b ? -rs2_data : rs2_data;
    div_zero = funct3[2] && (rs2_data == '0);
    ovf      = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (rs2_data == '1);
    spec_in  = div_zero | ovf;
    // divide-by-zero: quotient all-ones, remainder = dividend
    // signed overflow: quotient = dividend (most negative), remainder = 0
    if (div_zero) spec_val = funct3[1] ? rs1_data : '1;
    else          spec_val = funct3[1] ? '0 : rs1_data;
`ifdef MULDIV_FAST_MUL_EN
    fast_mul = ~funct3[2];
`else
    fast_mul = 1'b0;
`endif
    accept   = (state == IDLE) & start & ~flush;
  end

  // One iteration of each datapath.
  logic [XLEN:0]     mul_sum, rsh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
    rsh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = {1'b0, rsh} - {2'b00, opnd};
    // borrow means the trial subtract failed: keep the shifted remainder
    div_nxt = diff[XLEN+1] ? {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign correction and result select, valid while in DONE.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   sel;

  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    sel  = '0;
    if (special) sel = acc[XLEN-1:0];
    else begin
      case (op)
        3'b000:                 sel = prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: sel = prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         sel = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        default:                sel = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (spec_in | fast_mul) ? DONE : CALC;
      CALC:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) & ~flush;
  // The done cycle shows the fresh value; afterwards the registered copy holds it.
  assign result = done ? sel : result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      special  <= 1'b0;
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          op      <= funct3;
          sa      <= neg_a;
          sb      <= neg_b;
          special <= spec_in;
          cnt     <= '1;
          if (spec_in) acc <= {{XLEN{1'b0}}, spec_val};
          else if (funct3[2]) begin
            acc  <= {{XLEN{1'b0}}, abs_a};
            opnd <= abs_b;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc  <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`else
            acc  <= {{XLEN{1'b0}}, abs_b};
            opnd <= abs_a;
`endif
          end
        end
        CALC: begin
          acc <= op[2] ? div_nxt : mul_nxt;
          cnt <= cnt - 1'b1;
        end
        DONE: if (!flush) result_q <= sel;
        default: ;
      endcase
    end
  end

endmodule
